// File: rtl/pix_frame_tx_pkg.sv
// Shared state encoding and counter-width helpers for the pixel frame transmitter.
package pix_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VFRONT = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBACK  = 3'd4
  } state_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pix_frame_tx_timing.sv
// Frame timing generator: state machine plus pixel, line and shared blanking counters.
module pix_frame_tx_timing
  import pix_frame_tx_pkg::*;
#(
  parameter int Width  = 256,
  parameter int Height = 256,
  parameter int HBlank = 16,
  parameter int VFront = 8,
  parameter int VBack  = 8,
  localparam int PW = cnt_w(Width),
  localparam int LW = cnt_w(Height),
  localparam int BW = cnt_w(max3(HBlank, VFront, VBack))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output state_t        state,
  output logic          lv_next,
  output logic [PW-1:0] pixel,
  output logic [LW-1:0] line,
  output logic          frame_end
);

  state_t        state_nx;
  logic [PW-1:0] pixel_nx;
  logic [LW-1:0] line_nx;
  logic [BW-1:0] blank, blank_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pixel <= '0;
      line  <= '0;
      blank <= '0;
    end else begin
      state <= state_nx;
      pixel <= pixel_nx;
      line  <= line_nx;
      blank <= blank_nx;
    end
  end

  // Every counter reloads on entry to the state that uses it and stops at N-1.
  always_comb begin
    state_nx = state;
    pixel_nx = pixel;
    line_nx  = line;
    blank_nx = blank;
    case (state)
      ST_IDLE:
        if (start) begin
          state_nx = ST_VFRONT;
          blank_nx = '0;
        end
      ST_VFRONT:
        if (blank == BW'(VFront - 1)) begin
          state_nx = ST_LINE;
          pixel_nx = '0;
          line_nx  = '0;
        end else begin
          blank_nx = blank + BW'(1);
        end
      ST_LINE:
        if (pixel == PW'(Width - 1)) begin
          state_nx = (line == LW'(Height - 1)) ? ST_VBACK : ST_HBLANK;
          blank_nx = '0;
        end else begin
          pixel_nx = pixel + PW'(1);
        end
      ST_HBLANK:
        if (blank == BW'(HBlank - 1)) begin
          state_nx = ST_LINE;
          pixel_nx = '0;
          line_nx  = line + LW'(1);
        end else begin
          blank_nx = blank + BW'(1);
        end
      ST_VBACK:
        if (blank == BW'(VBack - 1)) state_nx = ST_IDLE;
        else                         blank_nx = blank + BW'(1);
      default: state_nx = ST_IDLE;
    endcase
    if (stop && state != ST_IDLE) state_nx = ST_IDLE;
  end

  assign lv_next   = (state == ST_LINE);
  assign frame_end = (state == ST_VBACK) && (blank == BW'(VBack - 1));

endmodule

// File: rtl/pix_frame_tx.sv
// Parallel pixel bus transmitter with sensor-style fv/lv timing fed from a ready/trigger source.
// Optional test pattern generator enabled by PIX_FRAME_TX_TESTPATTERN_EN.
module pix_frame_tx
  import pix_frame_tx_pkg::*;
#(
  parameter int Width  = 256,
  parameter int Height = 256,
  parameter int HBlank = 16,
  parameter int VFront = 8,
  parameter int VBack  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        src_ready,
  output logic        src_trigger,
  input  logic [15:0] src_data,
`ifdef PIX_FRAME_TX_TESTPATTERN_EN
  input  logic        tp_en,
`endif
  output logic [11:0] pix_d,
  output logic        pix_fv,
  output logic        pix_lv,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int PW = cnt_w(Width);
  localparam int LW = cnt_w(Height);

  state_t        state;
  logic          lv_next, frame_end;
  logic [PW-1:0] pixel;
  logic [LW-1:0] line;
  logic          start_ok, slot, src_mode;
  logic [11:0]   d_next;
  logic          unused_src;

  pix_frame_tx_timing #(
    .Width(Width), .Height(Height), .HBlank(HBlank), .VFront(VFront), .VBack(VBack)
  ) u_timing (
    .clk(clk), .rst(rst), .start(start_ok), .stop(cmd_stop),
    .state(state), .lv_next(lv_next), .pixel(pixel), .line(line), .frame_end(frame_end)
  );

  // Stop outranks start, and kills the current slot so no word is consumed on abort.
  assign start_ok = cmd_start && !cmd_stop && (state == ST_IDLE);
  assign slot     = lv_next && !cmd_stop;
  assign busy     = (state != ST_IDLE);

`ifdef PIX_FRAME_TX_TESTPATTERN_EN
  logic tp_mode;

  always_ff @(posedge clk) begin
    if (rst)           tp_mode <= 1'b0;
    else if (start_ok) tp_mode <= tp_en;
  end

  assign src_mode = !tp_mode;

  always_comb begin
    d_next = '0;
    if (slot) begin
      if (tp_mode)        d_next = {6'(line), 6'(pixel)};
      else if (src_ready) d_next = src_data[11:0];
    end
  end
`else
  logic unused_pos;
  assign unused_pos = ^{pixel, line};
  assign src_mode   = 1'b1;

  always_comb begin
    d_next = '0;
    if (slot && src_ready) d_next = src_data[11:0];
  end
`endif

  assign unused_src  = ^src_data[15:12];
  assign src_trigger = slot && src_ready && src_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_d    <= '0;
      pix_fv   <= 1'b0;
      pix_lv   <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      pix_d  <= d_next;
      pix_fv <= (state != ST_IDLE) && !cmd_stop;
      pix_lv <= slot;
      done   <= frame_end && !cmd_stop;
      if (start_ok)                             underrun <= 1'b0;
      else if (slot && !src_ready && src_mode)  underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pix_frame_tx.sv
// Directed bench for pix_frame_tx at Width=4 Height=2 HBlank=2 VFront=1 VBack=1.
module tb_pix_frame_tx;

  logic        clk = 1'b0, rst = 1'b1, cmd_start = 1'b0, cmd_stop = 1'b0, src_ready = 1'b1;
  logic        src_trigger;
  logic [15:0] src_data;
  logic [11:0] pix_d;
  logic        pix_fv, pix_lv, busy, done, underrun;
`ifdef PIX_FRAME_TX_TESTPATTERN_EN
  logic        tp_en = 1'b0;
`endif

  int total = 0, bad = 0;
  int idx = 0;
  logic take = 1'b0;
  int trig_cnt = 0, fv_cnt = 0, done_cnt = 0, lv_cnt = 0, lv_runs = 0;
  logic lv_prev = 1'b0;
  logic [11:0] pq[$];

  assign src_data = {4'hA, 12'(idx + 1)};

  pix_frame_tx #(.Width(4), .Height(2), .HBlank(2), .VFront(1), .VBack(1)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .src_ready(src_ready), .src_trigger(src_trigger), .src_data(src_data),
`ifdef PIX_FRAME_TX_TESTPATTERN_EN
    .tp_en(tp_en),
`endif
    .pix_d(pix_d), .pix_fv(pix_fv), .pix_lv(pix_lv), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Bus monitor samples mid-cycle, away from the launching edge.
  always @(negedge clk) begin
    take <= src_trigger;
    if (src_trigger) trig_cnt <= trig_cnt + 1;
    if (pix_fv)      fv_cnt   <= fv_cnt + 1;
    if (done)        done_cnt <= done_cnt + 1;
    if (pix_lv) begin
      lv_cnt <= lv_cnt + 1;
      pq.push_back(pix_d);
    end
    if (pix_lv && !lv_prev) lv_runs <= lv_runs + 1;
    lv_prev <= pix_lv;
  end

  // Source advances to the next word after each consuming edge.
  always @(posedge clk) begin
    #1;
    if (take) idx = idx + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trig_cnt = 0; fv_cnt = 0; done_cnt = 0; lv_cnt = 0; lv_runs = 0;
    pq.delete();
  endtask

  task automatic start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout got=0 want=1");
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (pix_d !== 12'h0)  begin bad++; $display("FAIL rst_pix_d got=%0h want=0", pix_d); end
    total++; if (pix_fv !== 1'b0)  begin bad++; $display("FAIL rst_fv got=%0b want=0", pix_fv); end
    total++; if (pix_lv !== 1'b0)  begin bad++; $display("FAIL rst_lv got=%0b want=0", pix_lv); end
    total++; if (src_trigger !== 1'b0) begin bad++; $display("FAIL rst_trig got=%0b want=0", src_trigger); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%0b want=0", underrun); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    int base;
    clr();
    base = idx;
    start();
    total++; if (busy !== 1'b1)   begin bad++; $display("FAIL norm_busy got=%0b want=1", busy); end
    total++; if (pix_fv !== 1'b0) begin bad++; $display("FAIL norm_fv_early got=%0b want=0", pix_fv); end
    tick();
    total++; if (pix_fv !== 1'b1) begin bad++; $display("FAIL norm_fv_rise got=%0b want=1", pix_fv); end
    total++; if (pix_lv !== 1'b0) begin bad++; $display("FAIL norm_lv_vfront got=%0b want=0", pix_lv); end
    tick();
    total++; if (pix_lv !== 1'b1) begin bad++; $display("FAIL norm_lv_rise got=%0b want=1", pix_lv); end
    wait_done();
    total++; if (trig_cnt !== 8)  begin bad++; $display("FAIL norm_trig got=%0d want=8", trig_cnt); end
    total++; if (lv_cnt !== 8)    begin bad++; $display("FAIL norm_lv_cycles got=%0d want=8", lv_cnt); end
    total++; if (lv_runs !== 2)   begin bad++; $display("FAIL norm_lv_runs got=%0d want=2", lv_runs); end
    total++; if (fv_cnt !== 12)   begin bad++; $display("FAIL norm_fv_cycles got=%0d want=12", fv_cnt); end
    total++; if (done_cnt !== 1)  begin bad++; $display("FAIL norm_done got=%0d want=1", done_cnt); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL norm_underrun got=%0b want=0", underrun); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL norm_busy_end got=%0b want=0", busy); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      total++;
      if (pq[i] !== 12'(base + 1 + i)) begin
        bad++; $display("FAIL norm_pix%0d got=%0h want=%0h", i, pq[i], 12'(base + 1 + i));
      end
    end
  endtask

  task automatic test_underrun();
    int base;
    logic [11:0] exp_d[8];
    clr();
    base = idx;
    exp_d[0] = 12'(base + 1); exp_d[1] = 12'(base + 2); exp_d[2] = 12'h0;
    for (int i = 3; i < 8; i++) exp_d[i] = 12'(base + i);
    start();
    tick(); tick(); tick();
    src_ready = 1'b0;
    tick();
    src_ready = 1'b1;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set got=%0b want=1", underrun); end
    total++; if (pix_lv !== 1'b1)   begin bad++; $display("FAIL ur_lv got=%0b want=1", pix_lv); end
    wait_done();
    total++; if (trig_cnt !== 7) begin bad++; $display("FAIL ur_trig got=%0d want=7", trig_cnt); end
    total++; if (lv_runs !== 2)  begin bad++; $display("FAIL ur_lv_runs got=%0d want=2", lv_runs); end
    total++; if (fv_cnt !== 12)  begin bad++; $display("FAIL ur_fv_cycles got=%0d want=12", fv_cnt); end
    total++; if (pq.size() !== 8) begin bad++; $display("FAIL ur_lv_cycles got=%0d want=8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      total++;
      if (pq[i] !== exp_d[i]) begin
        bad++; $display("FAIL ur_pix%0d got=%0h want=%0h", i, pq[i], exp_d[i]);
      end
    end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_sticky got=%0b want=1", underrun); end
    clr();
    start();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clear got=%0b want=0", underrun); end
    wait_done();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clean_frame got=%0b want=0", underrun); end
  endtask

  task automatic test_stop();
    clr();
    start();
    repeat (8) tick();
    cmd_stop = 1'b1;
    #1;
    total++; if (src_trigger !== 1'b0) begin bad++; $display("FAIL stop_trig_same got=%0b want=0", src_trigger); end
    tick();
    cmd_stop = 1'b0;
    total++; if (pix_fv !== 1'b0) begin bad++; $display("FAIL stop_fv got=%0b want=0", pix_fv); end
    total++; if (pix_lv !== 1'b0) begin bad++; $display("FAIL stop_lv got=%0b want=0", pix_lv); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL stop_busy got=%0b want=0", busy); end
    repeat (4) tick();
    total++; if (done_cnt !== 0)  begin bad++; $display("FAIL stop_done got=%0d want=0", done_cnt); end
    total++; if (trig_cnt !== 5)  begin bad++; $display("FAIL stop_trig got=%0d want=5", trig_cnt); end
    clr();
    start();
    wait_done();
    total++; if (trig_cnt !== 8) begin bad++; $display("FAIL stop_restart_trig got=%0d want=8", trig_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stop_restart_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_ignored_start();
    clr();
    start();
    repeat (3) tick();
    start();
    wait_done();
    total++; if (trig_cnt !== 8) begin bad++; $display("FAIL busy_start_trig got=%0d want=8", trig_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", done_cnt); end
    total++; if (fv_cnt !== 12)  begin bad++; $display("FAIL busy_start_fv got=%0d want=12", fv_cnt); end
    clr();
    cmd_start = 1'b1; cmd_stop = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_busy got=%0b want=0", busy); end
    repeat (3) tick();
    total++; if (fv_cnt !== 0)   begin bad++; $display("FAIL both_fv got=%0d want=0", fv_cnt); end
    total++; if (trig_cnt !== 0) begin bad++; $display("FAIL both_trig got=%0d want=0", trig_cnt); end
  endtask

  task automatic test_rst_mid();
    start();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (pix_fv !== 1'b0) begin bad++; $display("FAIL rvf_fv got=%0b want=0", pix_fv); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rvf_busy got=%0b want=0", busy); end
    tick();
    start();
    tick(); tick();
    src_ready = 1'b0;
    tick();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL rln_pre_ur got=%0b want=1", underrun); end
    rst = 1'b1;
    tick();
    total++; if (pix_d !== 12'h0)  begin bad++; $display("FAIL rln_pix_d got=%0h want=0", pix_d); end
    total++; if (pix_fv !== 1'b0)  begin bad++; $display("FAIL rln_fv got=%0b want=0", pix_fv); end
    total++; if (pix_lv !== 1'b0)  begin bad++; $display("FAIL rln_lv got=%0b want=0", pix_lv); end
    total++; if (src_trigger !== 1'b0) begin bad++; $display("FAIL rln_trig got=%0b want=0", src_trigger); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rln_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL rln_done got=%0b want=0", done); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rln_underrun got=%0b want=0", underrun); end
    rst = 1'b0;
    src_ready = 1'b1;
    tick();
    clr();
    start();
    wait_done();
    total++; if (trig_cnt !== 8) begin bad++; $display("FAIL rln_recover got=%0d want=8", trig_cnt); end
  endtask

`ifdef PIX_FRAME_TX_TESTPATTERN_EN
  task automatic test_pattern();
    logic [11:0] exp_d[8];
    for (int i = 0; i < 4; i++) begin
      exp_d[i]     = 12'(i);
      exp_d[i + 4] = 12'h040 + 12'(i);
    end
    clr();
    src_ready = 1'b0;
    tp_en = 1'b1;
    start();
    tp_en = 1'b0;
    wait_done();
    src_ready = 1'b1;
    total++; if (trig_cnt !== 0)    begin bad++; $display("FAIL tp_trig got=%0d want=0", trig_cnt); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL tp_underrun got=%0b want=0", underrun); end
    total++; if (pq.size() !== 8)   begin bad++; $display("FAIL tp_lv_cycles got=%0d want=8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      total++;
      if (pq[i] !== exp_d[i]) begin
        bad++; $display("FAIL tp_pix%0d got=%0h want=%0h", i, pq[i], exp_d[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_underrun();
    test_stop();
    test_ignored_start();
    test_rst_mid();
`ifdef PIX_FRAME_TX_TESTPATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
